// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multicycle MIPS main control FSM and its datapath.
//   opcode      IR[31:26] seen by the controller
//   zero        ALU zero flag
//   alu_op      000 add, 001 sub, 010 R-type funct, 011 I-type opcode
//   alu_src_a   0=PC, 1=A reg
//   alu_src_b   00=B, 01=4, 10=ext imm, 11=sext imm<<2
//   ext_zero    1=zero-extend immediate
//   iord        memory address select: 0=PC, 1=ALUOut
//   mem_we      data memory write strobe
//   ir_we       IR load enable
//   pc_we       PC load enable (branch condition already applied)
//   pc_src      00=ALU result, 01=ALUOut, 10=jump target
//   reg_we      register file write enable
//   reg_dst     0=rt, 1=rd
//   mem_to_reg  0=ALUOut, 1=MDR
//   instr_done  pulse on final state of every instruction
//   illegal_op  pulse in DECODE for an unsupported opcode
//   state       current FSM state (debug)
// master = controller side, slave = datapath side.
interface mips_mc_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero,
        output alu_op, alu_src_a, alu_src_b, ext_zero, iord, mem_we, ir_we,
               pc_we, pc_src, reg_we, reg_dst, mem_to_reg, instr_done,
               illegal_op, state
    );

    modport slave (
        output opcode, zero,
        input  alu_op, alu_src_a, alu_src_b, ext_zero, iord, mem_we, ir_we,
               pc_we, pc_src, reg_we, reg_dst, mem_to_reg, instr_done,
               illegal_op, state
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM. Sequences fetch/decode/execute/memory/
// writeback, decodes the IR opcode and drives every datapath select and
// write enable as Moore outputs of the current state. Memory states (FETCH,
// MEMRD, MEMWR) are held for MEM_WAIT extra cycles; the access takes effect
// on the final held cycle only.
// Ports:
//   clk   system clock, rising edge
//   rstb  asynchronous active-low reset
//   bus   controller side of mips_mc_ctrl_if (opcode/zero in, controls out)
module mips_mc_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic           clk,
    input  logic           rstb,
    mips_mc_ctrl_if.master bus
);
    localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_RTEX   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_IEX    = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0]    state_q;
    logic [3:0]    state_d;
    logic [WW-1:0] wait_cnt;
    logic          wait_last;
    logic          in_mem;

    assign wait_last = (wait_cnt == WW'(MEM_WAIT));
    assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = wait_last ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:               state_d = S_RTEX;
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI:       state_d = S_IEX;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = wait_last ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = wait_last ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = S_ALUWB;
            S_IEX:    state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // The wait counter only runs while a memory state is being held; any
    // state change (including memory-to-memory, e.g. MEMWR->FETCH) clears it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_RST;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (in_mem && (state_d == state_q))
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        bus.alu_op     = 3'b000;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.ext_zero   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_we     = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b = 2'b01;
                bus.ir_we     = wait_last;
                bus.pc_we     = wait_last;
            end
            S_DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = (state_d == S_FETCH);
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWR: begin
                bus.iord       = 1'b1;
                bus.mem_we     = wait_last;
                bus.instr_done = wait_last;
            end
            S_RTEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 3'b010;
            end
            S_ALUWB: begin
                bus.reg_we     = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_IEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = 3'b011;
                bus.ext_zero  = (bus.opcode[5:2] == 4'b0011);
            end
            S_IWB: begin
                bus.reg_we     = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = 3'b001;
                bus.pc_src     = 2'b01;
                bus.pc_we      = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.pc_src     = 2'b10;
                bus.pc_we      = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state = state_q;
endmodule
